fnd_scan_ctrl: RTL and testbench

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_scan_ctrl_pkg.sv | 50 +++++
 rtl/fnd_scan_ctrl_bin2bcd_seq.sv | 72 +++++++
 rtl/fnd_scan_ctrl.sv | 94 +++++++++
 tb/tb_fnd_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared constants and types for the stopwatch FND scanner: segment codes,
// display geometry and the binary-to-BCD converter state encoding.
package fnd_scan_ctrl_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int BIN_W      = 14;
   localparam int BCD_W      = 16;
   localparam int DP_BIT     = 7;

   localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

   // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_SHIFT = 2'd1,
      C_DONE  = 2'd2
   } conv_state_t;

   function automatic logic [7:0] seg_code(input logic [3:0] digit);
      logic [7:0] code;
      case (digit)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/fnd_scan_ctrl_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per cycle, 14 steps,
// then a single C_DONE cycle in which the caller captures bcd_o.
module bin2bcd_seq
   import fnd_scan_ctrl_pkg::*;
(
   input  logic             clk100Mhz,
   input  logic             rst,
   input  logic             start_i,
   input  logic [BIN_W-1:0] bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [BCD_W-1:0] bcd_o
);

   conv_state_t      state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [BCD_W-1:0] bcd_adj;

   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) begin
         state_q <= C_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         C_IDLE: begin
            if (start_i) begin
               bin_d   = bin_i;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = C_SHIFT;
            end
         end
         C_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 4'd1;
            if (cnt_q == 4'(BIN_W - 1))
               state_d = C_DONE;
         end
         C_DONE:  state_d = C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   assign busy_o = (state_q != C_IDLE);
   assign done_o = (state_q == C_DONE);
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed FND driver for the stopwatch (SS.cc): samples the
// centisecond value on tick, converts it to BCD and scans one digit per tick.
module fnd_scan_ctrl
   import fnd_scan_ctrl_pkg::*;
(
   input  logic             clk100Mhz,
   input  logic             rst,
   input  logic             tick,
   input  logic [BIN_W-1:0] segData,
   input  logic             idle,
   output logic [7:0]       seg,
   output logic [3:0]       an
);

   logic [BIN_W-1:0] clamped;
   logic             conv_start;
   logic             conv_busy;
   logic             conv_done;
   logic [BCD_W-1:0] conv_bcd;

   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [1:0]       idx_q, idx_d;
   logic             started_q, started_d;
   logic [7:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic [3:0]       digit;
   logic [7:0]       code;

   assign clamped    = (segData > MAX_VAL) ? MAX_VAL : segData;
   assign conv_start = tick & ~conv_busy;

   bin2bcd_seq u_bin2bcd (
      .clk100Mhz (clk100Mhz),
      .rst       (rst),
      .start_i   (conv_start),
      .bin_i     (clamped),
      .busy_o    (conv_busy),
      .done_o    (conv_done),
      .bcd_o     (conv_bcd)
   );

   always_ff @(posedge clk100Mhz or posedge rst) begin
      if (rst) begin
         bcd_q     <= '0;
         idx_q     <= '0;
         started_q <= 1'b0;
         seg_q     <= SEG_BLANK;
         an_q      <= 4'hF;
      end else begin
         bcd_q     <= bcd_d;
         idx_q     <= idx_d;
         started_q <= started_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   // Display register only changes in C_DONE, so a half-shifted value is never shown
   always_comb begin
      bcd_d = bcd_q;
      if (conv_done)
         bcd_d = conv_bcd;
   end

   always_comb begin
      digit = bcd_q[{idx_q, 2'b00} +: 4];
      code  = seg_code(digit);
      if (idle)
         code = SEG_DASH;
      else if (idx_q == 2'd2)
         code[DP_BIT] = 1'b0;
      else if ((idx_q == 2'd3) && (digit == 4'd0))
         code = SEG_BLANK;
   end

   // The tick cycle blanks all anodes; the new digit is driven on the following cycle
   always_comb begin
      idx_d     = idx_q;
      started_d = started_q;
      seg_d     = SEG_BLANK;
      an_d      = 4'hF;
      if (tick) begin
         idx_d     = idx_q + 2'd1;
         started_d = 1'b1;
      end else if (started_q) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = code;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: per-tick expected {an,seg} pushed to a
// queue from a decimal reference model, popped and compared after the blank cycle.
module tb_fnd_scan_ctrl;

   logic        clk100Mhz = 1'b0;
   logic        rst       = 1'b1;
   logic        tick      = 1'b0;
   logic [13:0] segData   = '0;
   logic        idle      = 1'b0;
   logic [7:0]  seg;
   logic [3:0]  an;

   int checks   = 0;
   int failures = 0;

   logic [11:0] exp_q[$];

   int idx_m;
   int shown_val;
   int pend_val;
   bit pend_valid;
   bit busy_m;

   logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   fnd_scan_ctrl dut (
      .clk100Mhz (clk100Mhz),
      .rst       (rst),
      .tick      (tick),
      .segData   (segData),
      .idle      (idle),
      .seg       (seg),
      .an        (an)
   );

   always #5 clk100Mhz = ~clk100Mhz;

   function automatic int clamp(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic logic [11:0] exp_of(input int val, input int idx, input logic idl);
      int d;
      logic [7:0] s;
      logic [3:0] a;
      case (idx)
         0:       begin d = val % 10;         a = 4'hE; end
         1:       begin d = (val / 10) % 10;  a = 4'hD; end
         2:       begin d = (val / 100) % 10; a = 4'hB; end
         default: begin d = val / 1000;       a = 4'h7; end
      endcase
      s = seg_tab[d];
      if (idl)
         s = 8'hBF;
      else if (idx == 2)
         s[7] = 1'b0;
      else if (idx == 3 && d == 0)
         s = 8'hFF;
      return {a, s};
   endfunction

   task automatic model_reset();
      idx_m      = 0;
      shown_val  = 0;
      pend_val   = 0;
      pend_valid = 0;
      busy_m     = 0;
      exp_q.delete();
   endtask

   // Drives one tick with value v, captures the blank-cycle anodes and the digit
   // that follows, then idles gap cycles (optionally scrambling segData).
   task automatic do_tick(input logic [13:0] v, input int gap, input bit scramble,
                          output logic [3:0] blank_an, output logic [11:0] obs);
      idx_m = (idx_m + 1) % 4;
      exp_q.push_back(exp_of(shown_val, idx_m, idle));
      if (!busy_m) begin
         pend_val   = clamp(int'(v));
         pend_valid = 1;
         busy_m     = 1;
      end
      @(negedge clk100Mhz);
      segData = v;
      tick    = 1'b1;
      @(negedge clk100Mhz);
      tick     = 1'b0;
      blank_an = an;
      @(negedge clk100Mhz);
      obs = {an, seg};
      for (int i = 0; i < gap; i++) begin
         @(negedge clk100Mhz);
         if (scramble)
            segData = 14'($urandom_range(0, 16383));
      end
      if (gap >= 20) begin
         if (pend_valid)
            shown_val = pend_val;
         pend_valid = 0;
         busy_m     = 0;
      end
   endtask

   task automatic test_reset();
      bit an_bad;
      rst = 1'b1;
      repeat (3) @(negedge clk100Mhz);
      checks++;
      if (seg !== 8'hFF) begin
         failures++;
         $display("FAIL reset_seg: got %h expected ff", seg);
      end
      checks++;
      if (an !== 4'hF) begin
         failures++;
         $display("FAIL reset_an: got %h expected f", an);
      end
      rst = 1'b0;
      model_reset();
      an_bad = 0;
      repeat (6) begin
         @(negedge clk100Mhz);
         if (an !== 4'hF) an_bad = 1;
      end
      checks++;
      if (an_bad) begin
         failures++;
         $display("FAIL reset_an_hold: got %h expected f before first tick", an);
      end
   endtask

   task automatic test_value(input string name, input logic [13:0] v, input int n);
      logic [3:0]  b;
      logic [11:0] obs, e;
      for (int k = 0; k < n; k++) begin
         do_tick(v, 25, 1'b0, b, obs);
         e = exp_q.pop_front();
         checks++;
         if (b !== 4'hF) begin
            failures++;
            $display("FAIL %s_blank[%0d]: got an=%h expected f", name, k, b);
         end
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s_digit[%0d]: got an,seg=%h expected %h", name, k, obs, e);
         end
      end
   endtask

   task automatic test_idle();
      logic [3:0]  b;
      logic [11:0] obs, e;
      idle = 1'b1;
      for (int k = 0; k < 5; k++) begin
         do_tick(14'd3456, 25, 1'b0, b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL idle_dash[%0d]: got an,seg=%h expected %h", k, obs, e);
         end
      end
      idle = 1'b0;
      for (int k = 0; k < 4; k++) begin
         do_tick(14'd3456, 25, 1'b0, b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL idle_fall[%0d]: got an,seg=%h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_ignored_tick();
      logic [3:0]  b;
      logic [11:0] obs, e;
      do_tick(14'd2468, 5, 1'b0, b, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL ign_first: got an,seg=%h expected %h", obs, e);
      end
      do_tick(14'd1357, 25, 1'b0, b, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL ign_during_conv: got an,seg=%h expected %h", obs, e);
      end
      for (int k = 0; k < 4; k++) begin
         do_tick(14'd2468, 25, 1'b0, b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL ign_kept[%0d]: got an,seg=%h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_reset_midshift();
      logic [3:0]  b;
      logic [11:0] obs, e;
      bit          an_bad;
      do_tick(14'd5000, 0, 1'b0, b, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL rstmid_pre: got an,seg=%h expected %h", obs, e);
      end
      repeat (3) @(negedge clk100Mhz);
      rst = 1'b1;
      #1;
      checks++;
      if ({an, seg} !== 12'hFFF) begin
         failures++;
         $display("FAIL rstmid_async: got an,seg=%h expected fff", {an, seg});
      end
      @(negedge clk100Mhz);
      rst = 1'b0;
      model_reset();
      an_bad = 0;
      repeat (20) begin
         @(negedge clk100Mhz);
         if (an !== 4'hF) an_bad = 1;
      end
      checks++;
      if (an_bad) begin
         failures++;
         $display("FAIL rstmid_an_hold: got %h expected f before first tick", an);
      end
      for (int k = 0; k < 5; k++) begin
         do_tick(14'd777, 25, 1'b0, b, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL rstmid_777[%0d]: got an,seg=%h expected %h", k, obs, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  b;
      logic [11:0] obs, e;
      logic [13:0] v;
      for (int k = 0; k < 10; k++) begin
         v = 14'($urandom_range(0, 16383));
         do_tick(v, 25, 1'b1, b, obs);
         e = exp_q.pop_front();
         checks++;
         if (b !== 4'hF) begin
            failures++;
            $display("FAIL b2b_blank[%0d]: got an=%h expected f", k, b);
         end
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL b2b_digit[%0d]: got an,seg=%h expected %h", k, obs, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_value("zero", 14'd0, 2);
      test_value("v1234", 14'd1234, 5);
      test_value("v45", 14'd45, 5);
      test_value("clamp", 14'd12000, 5);
      test_value("v9999", 14'd9999, 5);
      test_idle();
      test_ignored_tick();
      test_reset_midshift();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
